// File: rtl/vload_gather.sv
// Vector load sequencer: gathers up to LANES strided words from memory, then issues one multi-lane register write.
// Optional VLOAD_TIMEOUT_EN adds an err output and aborts a load after TIMEOUT_CYC ack-less request cycles.
module vload_gather #(
    parameter int LANES       = 5,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [2:0]        vector_size,
    input  logic [3:0]        dest,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              vwe,
    output logic [3:0]        vwa,
    output logic [2:0]        vsize_out,
    output logic [DATA_W-1:0] vwd1,
    output logic [DATA_W-1:0] vwd2,
    output logic [DATA_W-1:0] vwd3,
    output logic [DATA_W-1:0] vwd4,
    output logic [DATA_W-1:0] vwd5
`ifdef VLOAD_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    localparam logic [2:0] LANES_3 = 3'(LANES);

    // Lane outputs are hard-wired to five ports, so the lane count is fixed.
    if (LANES != 5 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("vload_gather: LANES must be 5 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_n;
    logic [2:0]        r_idx;
    logic [3:0]        r_dest;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_lane [LANES];
    logic [DATA_W-1:0] w_lane_out [LANES];
    logic [2:0]        w_clamp;
    logic              w_accept;
    logic              w_last;
    logic              w_abort_now;
    logic              w_aborted;

    assign w_clamp  = (vector_size > LANES_3) ? LANES_3 : vector_size;
    assign w_accept = (r_state == S_REQ) && mem_ack;
    assign w_last   = w_accept && ((r_idx + 3'd1) == r_n);

`ifdef VLOAD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] r_tmo;
    logic             r_abort;

    // Expires on the TIMEOUT_CYC-th consecutive request cycle without an ack.
    assign w_abort_now = (r_state == S_REQ) && !mem_ack && (r_tmo == '0);
    assign w_aborted   = r_abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo   <= '0;
            r_abort <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tmo   <= TMO_RELOAD;
                    r_abort <= 1'b0;
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_tmo <= TMO_RELOAD;
                    end else if (r_tmo != '0) begin
                        r_tmo <= r_tmo - 1'b1;
                    end
                    if (w_abort_now) begin
                        r_abort <= 1'b1;
                    end
                end
                default: begin
                    r_tmo <= r_tmo;
                end
            endcase
        end
    end

    assign err = (r_state == S_WRITE) && r_abort;
`else
    assign w_abort_now = 1'b0;
    assign w_aborted   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_clamp == 3'd0) ? S_WRITE : S_REQ;
                end
            end
            S_REQ: begin
                if (w_last || w_abort_now) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command latch, element gather and address stepping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_n      <= '0;
            r_idx    <= '0;
            r_dest   <= '0;
            r_stride <= '0;
            r_addr   <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_lane[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n      <= w_clamp;
                        r_idx    <= '0;
                        r_dest   <= dest;
                        r_stride <= stride;
                        r_addr   <= base_addr;
                        for (int k = 0; k < LANES; k++) begin
                            r_lane[k] <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (w_accept) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (3'(k) == r_idx) begin
                                r_lane[k] <= mem_rdata;
                            end
                        end
                        r_idx  <= r_idx + 3'd1;
                        r_addr <= r_addr + r_stride;
                    end else if (w_abort_now) begin
                        for (int k = 0; k < LANES; k++) begin
                            r_lane[k] <= '0;
                        end
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_lane_out[k] = (3'(k) < r_n) ? r_lane[k] : '0;
        end
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        mem_req   = (r_state == S_REQ);
        done      = (r_state == S_WRITE);
        vwe       = (r_state == S_WRITE) && (r_n != 3'd0) && !w_aborted;
        mem_addr  = r_addr;
        vwa       = r_dest;
        vsize_out = r_n;
        vwd1      = w_lane_out[0];
        vwd2      = w_lane_out[1];
        vwd3      = w_lane_out[2];
        vwd4      = w_lane_out[3];
        vwd5      = w_lane_out[4];
    end

endmodule

// File: tb/tb_vload_gather.sv
// Directed bench for vload_gather; memory returns addr>>2 as data so lane values are hand-computable.
`timescale 1ns/1ps
module tb_vload_gather;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] stride;
    logic [2:0]        vector_size;
    logic [3:0]        dest;
    logic              busy;
    logic              done;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              vwe;
    logic [3:0]        vwa;
    logic [2:0]        vsize_out;
    logic [DATA_W-1:0] vwd1, vwd2, vwd3, vwd4, vwd5;
`ifdef VLOAD_TIMEOUT_EN
    logic              err;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int reads;

    vload_gather #(.LANES(5), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
        .vector_size(vector_size), .dest(dest), .busy(busy), .done(done), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .vwe(vwe), .vwa(vwa),
        .vsize_out(vsize_out), .vwd1(vwd1), .vwd2(vwd2), .vwd3(vwd3), .vwd4(vwd4), .vwd5(vwd5)
`ifdef VLOAD_TIMEOUT_EN
        , .err(err)
`endif
    );

    assign mem_rdata = mem_addr >> 2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start in the current cycle; returns one cycle later (first request cycle).
    task automatic issue(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                         input logic [2:0] n, input logic [3:0] d);
        base_addr   = b;
        stride      = s;
        vector_size = n;
        dest        = d;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; mem_ack = 1'b0;
        base_addr = '0; stride = '0; vector_size = '0; dest = '0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_vwe", vwe, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_vwa", vwa, 0);
        chk("rst_vsize", vsize_out, 0);
        chk("rst_vwd1", vwd1, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Basic 5-element load, ack tied high
        mem_ack = 1'b1;
        issue(32'h100, 32'd4, 3'd5, 4'd3);
        for (int c = 1; c <= 5; c++) begin
            chk("t1_req", mem_req, 1);
            chk("t1_addr", mem_addr, 32'h100 + 32'(4 * (c - 1)));
            chk("t1_vwe_early", vwe, 0);
            tick();
        end
        chk("t1_vwe", vwe, 1);
        chk("t1_vwa", vwa, 3);
        chk("t1_vsize", vsize_out, 5);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 1);
        chk("t1_vwd1", vwd1, 32'h40);
        chk("t1_vwd2", vwd2, 32'h41);
        chk("t1_vwd3", vwd3, 32'h42);
        chk("t1_vwd4", vwd4, 32'h43);
        chk("t1_vwd5", vwd5, 32'h44);
        tick();
        chk("t1_done_after", done, 0);
        chk("t1_busy_after", busy, 0);
        chk("t1_vwe_after", vwe, 0);
        chk("t1_vwd1_hold", vwd1, 32'h40);

        // Two elements with three-cycle ack stalls
        mem_ack = 1'b0;
        issue(32'h200, 32'd8, 3'd2, 4'd6);
        reads = 0;
        for (int c = 1; c <= 8; c++) begin
            mem_ack = (c == 4 || c == 8);
            chk("t2_req", mem_req, 1);
            chk("t2_addr", mem_addr, (c <= 4) ? 32'h200 : 32'h208);
            if (mem_req && mem_ack) reads++;
            tick();
        end
        mem_ack = 1'b0;
        chk("t2_reads", reads, 2);
        chk("t2_vwe", vwe, 1);
        chk("t2_vwa", vwa, 6);
        chk("t2_vsize", vsize_out, 2);
        chk("t2_vwd1", vwd1, 32'h80);
        chk("t2_vwd2", vwd2, 32'h82);
        chk("t2_vwd3", vwd3, 0);
        chk("t2_vwd4", vwd4, 0);
        chk("t2_vwd5", vwd5, 0);
        tick();

        // Size 0: immediate done without a write
        issue(32'h300, 32'd4, 3'd0, 4'd1);
        chk("t3_z_done", done, 1);
        chk("t3_z_vwe", vwe, 0);
        chk("t3_z_req", mem_req, 0);
        chk("t3_z_busy", busy, 1);
        chk("t3_z_vsize", vsize_out, 0);
        chk("t3_z_vwd1", vwd1, 0);
        tick();
        chk("t3_z_done_after", done, 0);
        chk("t3_z_busy_after", busy, 0);

        // Size 7 clamps to 5
        mem_ack = 1'b1;
        issue(32'h300, 32'd4, 3'd7, 4'd2);
        reads = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) break;
            if (mem_req && mem_ack) reads++;
            tick();
        end
        chk("t3_s7_done", done, 1);
        chk("t3_s7_reads", reads, 5);
        chk("t3_s7_vwe", vwe, 1);
        chk("t3_s7_vsize", vsize_out, 5);
        chk("t3_s7_vwd5", vwd5, 32'hC4);
        tick();

        // Address wrap-around
        issue(32'hFFFF_FFF8, 32'd4, 3'd3, 4'd4);
        chk("t4_addr0", mem_addr, 32'hFFFF_FFF8);
        tick();
        chk("t4_addr1", mem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t4_addr2", mem_addr, 32'h0000_0000);
        tick();
        chk("t4_vwe", vwe, 1);
        chk("t4_vsize", vsize_out, 3);
        chk("t4_vwd1", vwd1, 32'h3FFF_FFFE);
        chk("t4_vwd2", vwd2, 32'h3FFF_FFFF);
        chk("t4_vwd3", vwd3, 0);
        tick();

        // Reset mid-command after two of four elements
        issue(32'h400, 32'd4, 3'd4, 4'd5);
        tick();
        tick();
        chk("t5_req_pre", mem_req, 1);
        chk("t5_addr_pre", mem_addr, 32'h408);
        #1 reset = 1'b0;
        #1;
        chk("t5_req_rst", mem_req, 0);
        chk("t5_busy_rst", busy, 0);
        chk("t5_addr_rst", mem_addr, 0);
        chk("t5_vwd1_rst", vwd1, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("t5_vwe_in_rst", vwe, 0);
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_vwe_post", vwe, 0);
            chk("t5_done_post", done, 0);
        end

        // Fresh single-element load; start while busy must be ignored
        issue(32'h500, 32'd4, 3'd1, 4'd9);
        chk("t5_new_addr", mem_addr, 32'h500);
        base_addr   = 32'h900;
        vector_size = 3'd3;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_new_vwe", vwe, 1);
        chk("t5_new_vwa", vwa, 9);
        chk("t5_new_vsize", vsize_out, 1);
        chk("t5_new_vwd1", vwd1, 32'h140);
        chk("t5_new_vwd2", vwd2, 0);
        tick();
        chk("t5_ign_req", mem_req, 0);
        chk("t5_ign_busy", busy, 0);
        tick();
        chk("t5_ign_req2", mem_req, 0);

`ifdef VLOAD_TIMEOUT_EN
        // No ack for 16 request cycles aborts the load
        mem_ack = 1'b0;
        issue(32'h600, 32'd4, 3'd2, 4'd7);
        for (int c = 1; c <= 16; c++) begin
            chk("t6_req", mem_req, 1);
            chk("t6_err_early", err, 0);
            tick();
        end
        chk("t6_err", err, 1);
        chk("t6_done", done, 1);
        chk("t6_vwe", vwe, 0);
        chk("t6_req_drop", mem_req, 0);
        chk("t6_vwd1", vwd1, 0);
        tick();
        chk("t6_err_after", err, 0);
        chk("t6_busy_after", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
